// File: rtl/efb_pkg.sv
// Shared EFB constants and types.
//   - efb_state_e : arbiter FSM state encoding
//   - cnt_width() : width of the strobe-wait counter for a given TIMEOUT
//   - default parameter values and the EFB data width
package efb_pkg;

  localparam int unsigned TimeoutDefault = 255;
  localparam int unsigned AdrWDefault    = 8;
  localparam int unsigned DatW           = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StBusy    = 2'd1,
    StAbort   = 2'd2,
    StWaitRel = 2'd3
  } efb_state_e;

  // Counter only has to reach TIMEOUT-1.
  function automatic int unsigned cnt_width(int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick.
//   req  : request vector, bit 0 = m0, bit 1 = m1
//   last : requester granted most recently (0 = m0, 1 = m1)
//   pick : one-hot winner, 00 when nobody requests
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  always_comb begin
    pick = req;
    // On contention the requester not served last wins.
    if (req == 2'b11) begin
      pick = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/efb_wb_arbiter.sv
// Two-requester Wishbone arbiter in front of the EFB slave port.
//   clk, rst_n              : clock, asynchronous active-low reset
//   m0_* / m1_*             : requester Wishbone ports (cyc/stb/we/adr/dat in, dat/ack/err out)
//   s_*                     : Wishbone master port toward the EFB
//   gnt_o                   : one-hot current grant (00 = none)
//   timeout_o               : one-cycle pulse when a granted strobe is aborted
// The granted requester is passed through combinationally while BUSY. A strobe left
// unacknowledged for TIMEOUT cycles is aborted with err_o; the grant is then held until
// the requester drops cyc.
module efb_wb_arbiter
  import efb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault,
  parameter int unsigned ADR_W   = AdrWDefault
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [DatW-1:0]  m0_dat_i,
  output logic [DatW-1:0]  m0_dat_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,

  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [DatW-1:0]  m1_dat_i,
  output logic [DatW-1:0]  m1_dat_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,

  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [DatW-1:0]  s_dat_o,
  input  logic [DatW-1:0]  s_dat_i,
  input  logic             s_ack_i,

  output logic [1:0]       gnt_o,
  output logic             timeout_o
);

  localparam int unsigned   CntW   = cnt_width(TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  efb_state_e      state_q;
  logic [1:0]      gnt_q;
  logic            last_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      pick;

  rr_pick2 u_rr_pick2 (
    .req  ({m1_cyc_i, m0_cyc_i}),
    .last (last_q),
    .pick (pick)
  );

  // Signals of whichever requester holds the grant.
  logic             g_cyc;
  logic             g_stb;
  logic             g_we;
  logic [ADR_W-1:0] g_adr;
  logic [DatW-1:0]  g_dat;

  always_comb begin
    g_cyc = m0_cyc_i;
    g_stb = m0_stb_i;
    g_we  = m0_we_i;
    g_adr = m0_adr_i;
    g_dat = m0_dat_i;
    if (gnt_q[1]) begin
      g_cyc = m1_cyc_i;
      g_stb = m1_stb_i;
      g_we  = m1_we_i;
      g_adr = m1_adr_i;
      g_dat = m1_dat_i;
    end
  end

  logic busy;
  logic abort;
  assign busy  = (state_q == StBusy);
  assign abort = (state_q == StAbort);

  assign s_cyc_o = busy & g_cyc;
  assign s_stb_o = busy & g_stb;
  assign s_we_o  = busy & g_we;
  assign s_adr_o = busy ? g_adr : '0;
  assign s_dat_o = busy ? g_dat : '0;

  // Slave ack/data only reach the granted requester, and only while BUSY.
  assign m0_ack_o = busy & gnt_q[0] & s_ack_i;
  assign m1_ack_o = busy & gnt_q[1] & s_ack_i;
  assign m0_dat_o = (busy & gnt_q[0]) ? s_dat_i : '0;
  assign m1_dat_o = (busy & gnt_q[1]) ? s_dat_i : '0;
  assign m0_err_o = abort & gnt_q[0];
  assign m1_err_o = abort & gnt_q[1];

  assign gnt_o     = gnt_q;
  assign timeout_o = abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;  // pretend m1 went last so m0 wins first
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (pick != 2'b00) begin
            gnt_q   <= pick;
            last_q  <= pick[1];
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (!g_cyc) begin
            gnt_q   <= 2'b00;
            cnt_q   <= '0;
            state_q <= StIdle;
          end else if (s_stb_o && !s_ack_i) begin
            // An ack in the cycle the counter sits at TIMEOUT-1 still succeeds.
            if (cnt_q == CntMax) begin
              cnt_q   <= '0;
              state_q <= StAbort;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end else begin
            cnt_q <= '0;
          end
        end
        StAbort: begin
          state_q <= StWaitRel;
        end
        StWaitRel: begin
          if (!g_cyc) begin
            gnt_q   <= 2'b00;
            state_q <= StIdle;
          end
        end
        default: begin
          gnt_q   <= 2'b00;
          cnt_q   <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
